grid_mover: RTL and testbench

Parametrised tile-grid movement controller for one maze actor (Pac-Man or a ghost). On each `step` tick it looks up wall bits for the candidate tile through an external synchronous map-ROM port, then commits the move. It prefers the buffered player/AI turn, falls back to the current heading, and otherwise stops. It sits between input decode (buttons or ghost AI) and the sprite renderer, replacing the fixed 32×32 linear-index mover.

---
 rtl/grid_pkg.sv | 11 +
 rtl/grid_neighbor.sv | 34 +++
 rtl/grid_mover.sv | 119 +++++++++++
 tb/tb_grid_mover.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// grid_pkg: shared direction/state types and press decoding for the tile-grid movers
package grid_pkg;
  typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_EVAL} mover_state_t;
  function automatic dir_t onehot_to_dir(input logic [3:0] udlr);
    return udlr == 4'b1000 ? DIR_UP :
           udlr == 4'b0100 ? DIR_DOWN :
           udlr == 4'b0010 ? DIR_LEFT :
           udlr == 4'b0001 ? DIR_RIGHT : DIR_NONE;
  endfunction
endpackage

// File: rtl/grid_neighbor.sv
// grid_neighbor: target tile one move from (row, col) in direction dir.
// Build option GRID_WRAP_EN: edges wrap to the opposite side instead of being off-grid.
module grid_neighbor
  import grid_pkg::*;
#(
  parameter int COLS = 32,
  parameter int ROWS = 32,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS)
) (
  input  logic [RW-1:0] row,
  input  logic [CW-1:0] col,
  input  dir_t          dir,
  output logic [RW-1:0] t_row,
  output logic [CW-1:0] t_col,
  output logic          off_grid
);
  logic top, bot, lft, rgt;
  always_comb begin
    top = dir == DIR_UP && row == '0;
    bot = dir == DIR_DOWN && row == RW'(ROWS - 1);
    lft = dir == DIR_LEFT && col == '0;
    rgt = dir == DIR_RIGHT && col == CW'(COLS - 1);
    t_row = top ? RW'(ROWS - 1) : bot ? '0 :
            dir == DIR_UP ? row - 1'b1 : dir == DIR_DOWN ? row + 1'b1 : row;
    t_col = lft ? CW'(COLS - 1) : rgt ? '0 :
            dir == DIR_LEFT ? col - 1'b1 : dir == DIR_RIGHT ? col + 1'b1 : col;
`ifdef GRID_WRAP_EN
    off_grid = 1'b0;
`else
    off_grid = top || bot || lft || rgt;
`endif
  end
endmodule

// File: rtl/grid_mover.sv
// grid_mover: tile-grid actor mover; buffered turn first, then current heading, else stop.
// Build option GRID_WRAP_EN (in grid_neighbor) turns grid edges into tunnels.
module grid_mover
  import grid_pkg::*;
#(
  parameter int COLS = 32,
  parameter int ROWS = 32,
  parameter int START_COL = 15,
  parameter int START_ROW = 15,
  parameter int MAP_LAT = 1,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            step,
  input  logic            up,
  input  logic            down,
  input  logic            left,
  input  logic            right,
  output logic            map_rd,
  output logic [RW-1:0]   map_row,
  input  logic [COLS-1:0] map_data,
  output logic [RW-1:0]   row,
  output logic [CW-1:0]   col,
  output dir_t            heading,
  output logic            moving,
  output logic            done
);
  localparam int LW = MAP_LAT > 1 ? $clog2(MAP_LAT) : 1;
  mover_state_t state;
  dir_t buf_dir, cand, press, buf_eff, nxt_cand;
  logic pass, tgt_off, nb_off, wall, go;
  logic [LW-1:0] cnt;
  logic [RW-1:0] tgt_row, nb_row;
  logic [CW-1:0] tgt_col, nb_col;
  logic [COLS-1:0] rev;
  for (genvar c = 0; c < COLS; c++) begin : g_rev
    assign rev[c] = map_data[COLS-1-c];
  end
  // The launch target is computed from the candidate the next REQ will use, so map_rd is registered.
  always_comb begin
    press = onehot_to_dir({up, down, left, right});
    buf_eff = press != DIR_NONE ? press : buf_dir;
    nxt_cand = state == S_IDLE && buf_eff != DIR_NONE ? buf_eff : heading;
    wall = tgt_off || rev[tgt_col];
    go = (state == S_IDLE && step && nxt_cand != DIR_NONE) ||
         (state == S_EVAL && wall && !pass && heading != DIR_NONE);
  end
  grid_neighbor #(.COLS(COLS), .ROWS(ROWS)) u_nb (
    .row(row),
    .col(col),
    .dir(nxt_cand),
    .t_row(nb_row),
    .t_col(nb_col),
    .off_grid(nb_off)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      pass <= 1'b0;
      cnt <= '0;
      row <= RW'(START_ROW);
      col <= CW'(START_COL);
      heading <= DIR_NONE;
      buf_dir <= DIR_NONE;
      cand <= DIR_NONE;
      tgt_row <= '0;
      tgt_col <= '0;
      tgt_off <= 1'b0;
      moving <= 1'b0;
      done <= 1'b0;
      map_rd <= 1'b0;
      map_row <= '0;
    end else begin
      done <= 1'b0;
      map_rd <= 1'b0;
      if (press != DIR_NONE) buf_dir <= press;
      case (state)
        S_IDLE: if (step && nxt_cand == DIR_NONE) begin
          done <= 1'b1;
          moving <= 1'b0;
        end
        S_REQ: begin
          state <= MAP_LAT == 1 ? S_EVAL : S_WAIT;
          cnt <= LW'(MAP_LAT > 1 ? MAP_LAT - 2 : 0);
        end
        S_WAIT: begin
          state <= cnt == '0 ? S_EVAL : S_WAIT;
          cnt <= cnt - 1'b1;
        end
        default: if (!wall) begin
          row <= tgt_row;
          col <= tgt_col;
          heading <= cand;
          moving <= 1'b1;
          done <= 1'b1;
          state <= S_IDLE;
          if (!pass && press == DIR_NONE && buf_dir == cand) buf_dir <= DIR_NONE;
        end else if (!go) begin
          heading <= DIR_NONE;
          moving <= 1'b0;
          done <= 1'b1;
          state <= S_IDLE;
        end
      endcase
      if (go) begin
        state <= S_REQ;
        pass <= state != S_IDLE || buf_eff == DIR_NONE;
        cand <= nxt_cand;
        tgt_row <= nb_row;
        tgt_col <= nb_col;
        tgt_off <= nb_off;
        map_rd <= !nb_off;
        map_row <= nb_row;
      end
    end
  end
endmodule

// File: tb/tb_grid_mover.sv
// tb_grid_mover: vector table plus scoreboard for grid_mover (MAP_LAT=1 and MAP_LAT=3 instances).
module tb_grid_mover;
  import grid_pkg::*;
  localparam int COLS = 32;
  localparam int ROWS = 32;
  typedef struct {
    int row;
    int col;
    dir_t head;
    logic mov;
    int lat;
    int reads;
    int mrow;
    int scyc;
  } exp_t;
  typedef struct {
    logic [3:0] p;
    bit same;
    int wr;
    int wc;
    bit wv;
    exp_t e;
  } vec_t;
  logic clk = 1'b0;
  logic reset, rst3, step, step3, up, down, left, right;
  logic map_rd, map_rd3, moving, moving3, done, done3;
  logic [4:0] map_row, map_row3, row, row3, col, col3;
  logic [COLS-1:0] map_data, map_data3, p1, p2;
  logic v1, v2;
  dir_t heading, heading3;
  logic [COLS-1:0] walls [ROWS];
  exp_t sb [$];
  vec_t vt [10];
  int checks = 0, errors = 0, cyc = 0, rd_cnt = 0, last_mrow = 0, done_cnt = 0, pushed = 0;

  grid_mover #(.MAP_LAT(1)) u_dut (
    .clk(clk), .reset(reset), .step(step), .up(up), .down(down), .left(left), .right(right),
    .map_rd(map_rd), .map_row(map_row), .map_data(map_data), .row(row), .col(col),
    .heading(heading), .moving(moving), .done(done)
  );
  grid_mover #(.MAP_LAT(3)) u_l3 (
    .clk(clk), .reset(rst3), .step(step3), .up(up), .down(down), .left(left), .right(right),
    .map_rd(map_rd3), .map_row(map_row3), .map_data(map_data3), .row(row3), .col(col3),
    .heading(heading3), .moving(moving3), .done(done3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Map ROMs return junk whenever the data is not valid, so early/late sampling shows up.
  always @(posedge clk) map_data <= map_rd ? walls[map_row] : $urandom;
  always @(posedge clk) begin
    p1 <= walls[map_row3];
    v1 <= map_rd3;
    p2 <= p1;
    v2 <= v1;
    map_data3 <= v2 ? p2 : $urandom;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input int r, input int c, input dir_t h, input logic m,
                              input int lat, input int rd, input int mr);
    exp_t e;
    e.row = r;
    e.col = c;
    e.head = h;
    e.mov = m;
    e.lat = lat;
    e.reads = rd;
    e.mrow = mr;
    e.scyc = 0;
    return e;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (map_rd) begin
      rd_cnt++;
      last_mrow = int'(map_row);
    end
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("row", int'(row), e.row);
        chk("col", int'(col), e.col);
        chk("heading", int'(heading), int'(e.head));
        chk("moving", int'(moving), int'(e.mov));
        chk("latency", cyc - e.scyc, e.lat);
        chk("map_reads", rd_cnt, e.reads);
        if (e.reads > 0) chk("map_row", last_mrow, e.mrow);
        rd_cnt = 0;
      end
    end
  end

  // extra > 0 raises step again in cycle n+extra, while the mover is still resolving.
  task automatic do_step(input logic [3:0] p, input bit same, input exp_t e, input int extra);
    @(negedge clk);
    {up, down, left, right} = p;
    if (!same) begin
      @(negedge clk);
      {up, down, left, right} = 4'b0000;
    end
    step = 1'b1;
    e.scyc = cyc;
    sb.push_back(e);
    pushed++;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      {up, down, left, right} = 4'b0000;
      step = k == extra;
      if (sb.size() == 0) break;
    end
    step = 1'b0;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL step_timeout: got no done, expected done within 20 cycles");
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int got;
    bit seen;
    for (int r = 0; r < ROWS; r++) walls[r] = '0;
    {reset, rst3, step, step3, up, down, left, right} = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rst3 = 1'b1;
    @(negedge clk);
    chk("rst_row", int'(row), 15);
    chk("rst_col", int'(col), 15);
    chk("rst_heading", int'(heading), int'(DIR_NONE));
    chk("rst_map_rd", int'(map_rd), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_moving", int'(moving), 0);
    vt[0] = '{4'b0000, 1'b0, -1, 0, 1'b0, mk(15, 15, DIR_NONE, 1'b0, 1, 0, 0)};
    vt[1] = '{4'b0001, 1'b0, -1, 0, 1'b0, mk(15, 16, DIR_RIGHT, 1'b1, 3, 1, 15)};
    vt[2] = '{4'b0000, 1'b0, -1, 0, 1'b0, mk(15, 17, DIR_RIGHT, 1'b1, 3, 1, 15)};
    vt[3] = '{4'b1000, 1'b0, 14, 17, 1'b1, mk(15, 18, DIR_RIGHT, 1'b1, 5, 2, 15)};
    vt[4] = '{4'b0000, 1'b0, 14, 17, 1'b0, mk(14, 18, DIR_UP, 1'b1, 3, 1, 14)};
    vt[5] = '{4'b0000, 1'b0, 13, 18, 1'b1, mk(14, 18, DIR_NONE, 1'b0, 3, 1, 13)};
    vt[6] = '{4'b0100, 1'b0, -1, 0, 1'b0, mk(15, 18, DIR_DOWN, 1'b1, 3, 1, 15)};
    vt[7] = '{4'b1000, 1'b0, -1, 0, 1'b0, mk(14, 18, DIR_UP, 1'b1, 3, 1, 14)};
    vt[8] = '{4'b0010, 1'b1, -1, 0, 1'b0, mk(14, 17, DIR_LEFT, 1'b1, 3, 1, 14)};
    vt[9] = '{4'b1010, 1'b0, -1, 0, 1'b0, mk(14, 16, DIR_LEFT, 1'b1, 3, 1, 14)};
    for (int i = 0; i < 10; i++) begin
      if (vt[i].wr >= 0) walls[vt[i].wr][COLS-1-vt[i].wc] = vt[i].wv;
      do_step(vt[i].p, vt[i].same, vt[i].e, 0);
    end
    for (int c = 15; c >= 0; c--) do_step(4'b0000, 1'b0, mk(14, c, DIR_LEFT, 1'b1, 3, 1, 14), 0);
`ifdef GRID_WRAP_EN
    do_step(4'b0000, 1'b0, mk(14, 31, DIR_LEFT, 1'b1, 3, 1, 14), 0);
    do_step(4'b0001, 1'b0, mk(14, 0, DIR_RIGHT, 1'b1, 3, 1, 14), 2);
`else
    do_step(4'b0000, 1'b0, mk(14, 0, DIR_NONE, 1'b0, 3, 0, 0), 0);
    do_step(4'b0001, 1'b0, mk(14, 1, DIR_RIGHT, 1'b1, 3, 1, 14), 2);
`endif
    repeat (6) @(negedge clk);
    chk("done_count", done_cnt, pushed);
    {up, down, left, right} = 4'b0001;
    @(negedge clk);
    {up, down, left, right} = 4'b0000;
    step3 = 1'b1;
    got = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      step3 = 1'b0;
      if (done3) begin
        got = k;
        break;
      end
    end
    chk("lat3_latency", got, 5);
    chk("lat3_col", int'(col3), 16);
    chk("lat3_heading", int'(heading3), int'(DIR_RIGHT));
    repeat (3) @(negedge clk);
    step3 = 1'b1;
    @(negedge clk);
    step3 = 1'b0;
    @(negedge clk);
    rst3 = 1'b0;
    @(negedge clk);
    chk("midrst_row", int'(row3), 15);
    chk("midrst_col", int'(col3), 15);
    chk("midrst_map_rd", int'(map_rd3), 0);
    rst3 = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done3) seen = 1'b1;
    end
    chk("midrst_no_done", int'(seen), 0);
    chk("midrst_col_after", int'(col3), 15);
    chk("midrst_heading", int'(heading3), int'(DIR_NONE));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
